high_prior_rr_allocator: RTL and testbench

HIGH_PRIOR_RR_ALLOCATOR -- requirements
Module: high_prior_rr_allocator

---
 rtl/high_prior_rr_allocator.sv | 126 ++++++++++++
 tb/tb_high_prior_rr_allocator.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/high_prior_rr_allocator.sv
// Round-robin packet allocator for one shared output port.
//
// An idle output is granted to the first requester at or after a rotating
// pointer. The winner keeps the output until one of its tail flits is
// accepted, and the pointer then advances past it. While an input owns the
// output, its valid/ready handshake is passed straight through.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   req_i    per-input request (head flit waiting)
//   valid_i  per-input flit valid
//   tail_i   per-input "current flit is a tail"
//   ready_o  per-input flit accept (only the owner may see ready)
//   valid_o  flit valid toward the shared output
//   ready_i  downstream accept
//   grant_o  one-hot grant, zero when idle
//   sel_o    index of the granted input, zero when idle
//   busy_o   output is locked to a packet
module high_prior_rr_allocator #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req_i,
   input  logic [N_REQ-1:0] valid_i,
   input  logic [N_REQ-1:0] tail_i,
   output logic [N_REQ-1:0] ready_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [IDX_W-1:0] sel_o,
   output logic             busy_o
);

   typedef enum logic [0:0] {
      StIdle,
      StLock
   } state_e;

   state_e           r_state, w_state_nxt;
   logic [N_REQ-1:0] r_grant, w_grant_nxt;
   logic [IDX_W-1:0] r_sel, w_sel_nxt;
   logic [IDX_W-1:0] r_ptr, w_ptr_nxt;

   logic             w_found;
   logic [IDX_W-1:0] w_pick;
   logic [IDX_W:0]   w_scan_sum;
   logic [IDX_W-1:0] w_scan_idx;
   logic             w_xfer;
   logic             w_tail_xfer;

   // Scan upward from r_ptr, wrapping modulo N_REQ; the first hit wins.
   always_comb begin
      w_found    = 1'b0;
      w_pick     = '0;
      w_scan_sum = '0;
      w_scan_idx = '0;
      for (int k = 0; k < int'(N_REQ); k++) begin
         w_scan_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
         if (w_scan_sum >= (IDX_W+1)'(N_REQ)) begin
            w_scan_sum = w_scan_sum - (IDX_W+1)'(N_REQ);
         end
         w_scan_idx = w_scan_sum[IDX_W-1:0];
         if (!w_found && req_i[w_scan_idx]) begin
            w_found = 1'b1;
            w_pick  = w_scan_idx;
         end
      end
   end

   assign w_xfer      = (r_state == StLock) && valid_i[r_sel] && ready_i;
   assign w_tail_xfer = w_xfer && tail_i[r_sel];

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_sel_nxt   = r_sel;
      w_ptr_nxt   = r_ptr;
      unique case (r_state)
         StIdle: begin
            if (w_found) begin
               w_state_nxt = StLock;
               w_grant_nxt = N_REQ'(1) << w_pick;
               w_sel_nxt   = w_pick;
            end
         end
         StLock: begin
            // Only a tail transfer releases the lock; req_i is ignored here.
            if (w_tail_xfer) begin
               w_state_nxt = StIdle;
               w_grant_nxt = '0;
               w_sel_nxt   = '0;
               w_ptr_nxt   = (r_sel == IDX_W'(N_REQ - 1)) ? '0 : r_sel + IDX_W'(1);
            end
         end
         default: begin
            w_state_nxt = StIdle;
            w_grant_nxt = '0;
            w_sel_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
         r_grant <= '0;
         r_sel   <= '0;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_sel   <= w_sel_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   assign busy_o  = (r_state == StLock);
   assign grant_o = r_grant;
   assign sel_o   = r_sel;
   assign valid_o = busy_o && valid_i[r_sel];
   assign ready_o = (busy_o && ready_i) ? (N_REQ'(1) << r_sel) : '0;

endmodule

// File: tb/tb_high_prior_rr_allocator.sv
module tb_high_prior_rr_allocator;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req_i, valid_i, tail_i;
   logic [N-1:0] ready_o, grant_o;
   logic         valid_o, ready_i, busy_o;
   logic [1:0]   sel_o;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Model: owner index (-1 = nobody) and next scan start.
   int m_owner = -1;
   int m_ptr   = 0;

   always #5 clk = ~clk;

   high_prior_rr_allocator #(.N_REQ(4), .IDX_W(2)) dut (
      .clk     (clk),
      .rst     (rst),
      .req_i   (req_i),
      .valid_i (valid_i),
      .tail_i  (tail_i),
      .ready_o (ready_o),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .grant_o (grant_o),
      .sel_o   (sel_o),
      .busy_o  (busy_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update: arbitration rules stated directly on owner/pointer.
   always @(posedge clk) begin
      if (rst) begin
         m_owner = -1;
         m_ptr   = 0;
      end else if (m_owner < 0) begin
         for (int k = 0; k < N; k++) begin
            if (m_owner < 0 && req_i[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
         end
      end else if (valid_i[m_owner] && ready_i && tail_i[m_owner]) begin
         m_ptr   = (m_owner + 1) % N;
         m_owner = -1;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [N-1:0] e_grant, e_ready;
         logic         e_valid;
         e_grant = '0;
         e_ready = '0;
         e_valid = 1'b0;
         if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_valid          = valid_i[m_owner];
            e_ready[m_owner] = ready_i;
         end
         check("m_grant", 32'(grant_o), 32'(e_grant));
         check("m_sel",   32'(sel_o),   (m_owner < 0) ? 32'd0 : 32'(m_owner));
         check("m_busy",  32'(busy_o),  32'(m_owner >= 0));
         check("m_valid", 32'(valid_o), 32'(e_valid));
         check("m_ready", 32'(ready_o), 32'(e_ready));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      req_i = '0; valid_i = '0; tail_i = '0; ready_i = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_in();
      tick();
      tick();
      chk_en = 1'b1;
      check("rst_grant", 32'(grant_o), 32'd0);
      check("rst_busy",  32'(busy_o),  32'd0);
      rst = 1'b0;
      tick();
      check("idle_busy", 32'(busy_o), 32'd0);

      // Single request on input 2.
      req_i = 4'b0100;
      tick();
      check("single_grant", 32'(grant_o), 32'b0100);
      check("single_sel",   32'(sel_o),   32'd2);
      check("single_busy",  32'(busy_o),  32'd1);
      valid_i = 4'b0100; tail_i = 4'b0100; ready_i = 1'b1; req_i = '0;
      tick();
      check("single_rel", 32'(busy_o), 32'd0);

      // Wrap-around: ptr is now 3.
      idle_in();
      req_i = 4'b1001;
      tick();
      check("wrap_grant3", 32'(grant_o), 32'b1000);
      check("wrap_sel3",   32'(sel_o),   32'd3);
      valid_i = 4'b1000; tail_i = 4'b1000; ready_i = 1'b1;
      tick();
      check("wrap_rel", 32'(busy_o), 32'd0);
      valid_i = '0; tail_i = '0;
      tick();
      check("wrap_grant0", 32'(grant_o), 32'b0001);
      valid_i = 4'b0001; tail_i = 4'b0001;
      tick();
      idle_in();

      // Round-robin rotation with single-flit packets.
      do_reset();
      req_i = 4'b1111; valid_i = 4'b1111; tail_i = 4'b1111; ready_i = 1'b1;
      for (int p = 0; p < 5; p++) begin
         tick();
         check("rr_grant", 32'(grant_o), 32'd1 << (p % N));
         tick();
         check("rr_gap", 32'(busy_o), 32'd0);
      end
      idle_in();

      // Backpressure on a 3-flit packet from input 1.
      do_reset();
      req_i = 4'b0010;
      tick();
      check("bp_grant", 32'(grant_o), 32'b0010);
      req_i = '0; valid_i = 4'b0010; ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         check("bp_hold",  32'(grant_o), 32'b0010);
         check("bp_ready", 32'(ready_o), 32'd0);
      end
      ready_i = 1'b1;
      tick();
      check("bp_mid", 32'(busy_o), 32'd1);
      tail_i = 4'b0010;
      tick();
      check("bp_rel", 32'(busy_o), 32'd0);
      idle_in();

      // Request withdrawal while locked on input 2.
      do_reset();
      req_i = 4'b0100;
      tick();
      req_i = 4'b0001;
      tick();
      tick();
      check("wd_hold", 32'(grant_o), 32'b0100);
      valid_i = 4'b0100; tail_i = 4'b0100; ready_i = 1'b1;
      tick();
      check("wd_rel", 32'(busy_o), 32'd0);
      valid_i = '0; tail_i = '0;
      tick();
      check("wd_next", 32'(grant_o), 32'b0001);
      valid_i = 4'b0001; tail_i = 4'b0001;
      tick();
      idle_in();

      // Reset mid-packet on input 1.
      do_reset();
      req_i = 4'b0010;
      tick();
      valid_i = 4'b0010; ready_i = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      check("mrst_grant", 32'(grant_o), 32'd0);
      check("mrst_busy",  32'(busy_o),  32'd0);
      check("mrst_valid", 32'(valid_o), 32'd0);
      rst = 1'b0;
      req_i = 4'b1010; valid_i = '0;
      tick();
      check("mrst_first", 32'(grant_o), 32'b0010);
      valid_i = 4'b0010; tail_i = 4'b0010;
      tick();
      idle_in();

      // Random traffic, checked only by the model.
      for (int c = 0; c < 400; c++) begin
         rst     = ($urandom_range(0, 59) == 0);
         req_i   = N'($urandom);
         valid_i = N'($urandom);
         tail_i  = N'($urandom);
         ready_i = 1'($urandom);
         tick();
      end
      rst = 1'b0;
      idle_in();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
